// File: rtl/pacman_pkg.sv
// Shared direction codes, game states and direction helpers for the Pac-Man input path.
package pacman_pkg;

   typedef logic [1:0] dir_t;

   localparam dir_t DIR_UP    = 2'd0;
   localparam dir_t DIR_LEFT  = 2'd1;
   localparam dir_t DIR_DOWN  = 2'd2;
   localparam dir_t DIR_RIGHT = 2'd3;

   typedef enum logic [1:0] {
      GS_IDLE  = 2'd0,
      GS_PLAY  = 2'd1,
      GS_PAUSE = 2'd2,
      GS_OVER  = 2'd3
   } game_state_t;

   // Opposite directions differ only in bit 1 of the code.
   function automatic dir_t reverse_dir(input dir_t d);
      return d ^ 2'b10;
   endfunction

endpackage

// File: rtl/pacman_turn_buffer.sv
// Holds one pending turn request; register outputs, 1-cycle update, no backpressure.
// TURN_EXPIRE_EN adds a BUF_TICKS countdown on tile ticks that drops stale requests.
module pacman_turn_buffer
   import pacman_pkg::*;
#(
   parameter int unsigned BUF_TICKS = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_load,
   input  dir_t i_load_dir,
   input  logic i_clear,
   input  logic i_tick,
   input  logic i_commit,
   output logic o_eff_pending,
   output dir_t o_eff_dir,
   output logic o_req_pending,
   output dir_t o_req_dir
);

   if (BUF_TICKS < 1 || BUF_TICKS > 15) begin : g_bad_buf_ticks
      $error("pacman_turn_buffer: BUF_TICKS must be 1..15");
   end

   logic r_req_pending;
   dir_t r_req_dir;
   logic w_eff_pending;
   dir_t w_eff_dir;
   logic w_expire;
   logic w_pending_n;

   // Effective request: what the tile evaluation sees after this cycle's key.
   always_comb begin
      w_eff_pending = r_req_pending;
      w_eff_dir     = r_req_dir;
      if (i_clear) begin
         w_eff_pending = 1'b0;
      end else if (i_load) begin
         w_eff_pending = 1'b1;
         w_eff_dir     = i_load_dir;
      end
   end

`ifdef TURN_EXPIRE_EN
   localparam logic [3:0] LP_TICKS = 4'(BUF_TICKS);

   logic [3:0] r_cnt;
   logic [3:0] w_cnt_n;

   always_comb begin
      w_cnt_n  = r_cnt;
      w_expire = 1'b0;
      if (i_clear) begin
         w_cnt_n = 4'd0;
      end else if (i_load) begin
         w_cnt_n = LP_TICKS;
      end
      if (i_tick && w_eff_pending && !i_commit) begin
         if (w_cnt_n != 4'd0) begin
            w_cnt_n = w_cnt_n - 4'd1;
         end
         if (w_cnt_n == 4'd0) begin
            w_expire = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= 4'd0;
      end else begin
         r_cnt <= w_cnt_n;
      end
   end
`else
   assign w_expire = 1'b0;
`endif

   assign w_pending_n = w_eff_pending && !(i_tick && i_commit) && !w_expire;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_req_pending <= 1'b0;
         r_req_dir     <= DIR_UP;
      end else begin
         r_req_pending <= w_pending_n;
         r_req_dir     <= w_eff_dir;
      end
   end

   assign o_eff_pending = w_eff_pending;
   assign o_eff_dir     = w_eff_dir;
   assign o_req_pending = r_req_pending;
   assign o_req_dir     = r_req_dir;

endmodule

// File: rtl/pacman_input_sequencer.sv
// Game FSM plus turn buffering: key pulses become a registered direction one cycle later.
// No backpressure; TURN_EXPIRE_EN enables expiry of buffered turns after BUF_TICKS tile steps.
module pacman_input_sequencer
   import pacman_pkg::*;
#(
   parameter int unsigned BUF_TICKS = 4,
   parameter dir_t        INIT_DIR  = DIR_LEFT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_move_up,
   input  logic       i_move_down,
   input  logic       i_move_left,
   input  logic       i_move_right,
   input  logic       i_start_game,
   input  logic       i_tile_step,
   input  logic [3:0] i_wall_mask,
   input  logic       i_game_over,
   output logic [1:0] o_cur_dir,
   output logic       o_moving,
   output logic       o_req_pending,
   output logic [1:0] o_req_dir,
   output logic [1:0] o_game_state,
   output logic       o_game_active
);

   game_state_t r_state;
   dir_t        r_cur_dir;
   logic        r_moving;
   logic        r_moving_saved;
   logic        r_game_active;

   game_state_t w_state_n;
   dir_t        w_cur_n;
   logic        w_mov_n;
   logic        w_saved_n;
   logic        w_cand_vld;
   dir_t        w_cand_dir;
   logic        w_load;
   logic        w_clear;
   logic        w_tick;
   logic        w_commit;
   logic        w_eff_pending;
   dir_t        w_eff_dir;
   logic        w_req_pending;
   dir_t        w_req_dir;

   assign w_cand_vld = i_move_up | i_move_left | i_move_down | i_move_right;

   always_comb begin
      w_cand_dir = DIR_UP;
      if (i_move_up) begin
         w_cand_dir = DIR_UP;
      end else if (i_move_left) begin
         w_cand_dir = DIR_LEFT;
      end else if (i_move_down) begin
         w_cand_dir = DIR_DOWN;
      end else if (i_move_right) begin
         w_cand_dir = DIR_RIGHT;
      end
   end

   always_comb begin
      w_state_n = r_state;
      w_cur_n   = r_cur_dir;
      w_mov_n   = r_moving;
      w_saved_n = r_moving_saved;
      w_load    = 1'b0;
      w_clear   = 1'b0;
      w_tick    = 1'b0;
      w_commit  = 1'b0;
      case (r_state)
         GS_IDLE: begin
            w_clear = 1'b1;
            if (i_start_game) begin
               w_state_n = GS_PLAY;
               w_mov_n   = 1'b1;
            end
         end
         GS_PLAY: begin
            if (i_game_over) begin
               w_state_n = GS_OVER;
               w_mov_n   = 1'b0;
               w_clear   = 1'b1;
            end else if (i_start_game) begin
               w_state_n = GS_PAUSE;
               w_saved_n = r_moving;
               w_mov_n   = 1'b0;
            end else begin
               if (w_cand_vld) begin
                  if (w_cand_dir == reverse_dir(r_cur_dir)) begin
                     w_cur_n = w_cand_dir;
                     w_mov_n = 1'b1;
                     w_clear = 1'b1;
                  end else if (w_cand_dir == r_cur_dir) begin
                     w_clear = 1'b1;
                  end else begin
                     w_load = 1'b1;
                  end
               end
               // Tile evaluation sees the request and direction already updated by this cycle's key.
               if (i_tile_step) begin
                  w_tick = 1'b1;
                  if (w_eff_pending && !i_wall_mask[w_eff_dir]) begin
                     w_cur_n  = w_eff_dir;
                     w_mov_n  = 1'b1;
                     w_commit = 1'b1;
                  end else if (i_wall_mask[w_cur_n]) begin
                     w_mov_n = 1'b0;
                  end else begin
                     w_mov_n = 1'b1;
                  end
               end
            end
         end
         GS_PAUSE: begin
            if (i_start_game) begin
               w_state_n = GS_PLAY;
               w_mov_n   = r_moving_saved;
            end
         end
         GS_OVER: begin
            w_clear = 1'b1;
            if (i_start_game) begin
               w_state_n = GS_IDLE;
               w_cur_n   = INIT_DIR;
               w_mov_n   = 1'b0;
            end
         end
         default: begin
            w_state_n = GS_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= GS_IDLE;
         r_cur_dir      <= INIT_DIR;
         r_moving       <= 1'b0;
         r_moving_saved <= 1'b0;
         r_game_active  <= 1'b0;
      end else begin
         r_state        <= w_state_n;
         r_cur_dir      <= w_cur_n;
         r_moving       <= w_mov_n;
         r_moving_saved <= w_saved_n;
         r_game_active  <= (w_state_n == GS_PLAY);
      end
   end

   pacman_turn_buffer #(
      .BUF_TICKS (BUF_TICKS)
   ) u_turn_buffer (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_load        (w_load),
      .i_load_dir    (w_cand_dir),
      .i_clear       (w_clear),
      .i_tick        (w_tick),
      .i_commit      (w_commit),
      .o_eff_pending (w_eff_pending),
      .o_eff_dir     (w_eff_dir),
      .o_req_pending (w_req_pending),
      .o_req_dir     (w_req_dir)
   );

   assign o_cur_dir     = r_cur_dir;
   assign o_moving      = r_moving;
   assign o_req_pending = w_req_pending;
   assign o_req_dir     = w_req_dir;
   assign o_game_state  = r_state;
   assign o_game_active = r_game_active;

endmodule

// File: tb/tb_pacman_input_sequencer.sv
// Directed bench for pacman_input_sequencer with BUF_TICKS=2; expiry expectation follows TURN_EXPIRE_EN.
module tb_pacman_input_sequencer;

   logic       clk;
   logic       rst_n;
   logic       move_up, move_down, move_left, move_right;
   logic       start_game, tile_step, game_over;
   logic [3:0] wall_mask;
   logic [1:0] cur_dir, req_dir, game_state;
   logic       moving, req_pending, game_active;

   int n_checks = 0;
   int n_pass   = 0;

   // Key vectors indexed by direction code.
   localparam logic [3:0] K_NONE  = 4'b0000;
   localparam logic [3:0] K_UP    = 4'b0001;
   localparam logic [3:0] K_LEFT  = 4'b0010;
   localparam logic [3:0] K_DOWN  = 4'b0100;
   localparam logic [3:0] K_RIGHT = 4'b1000;

`ifdef TURN_EXPIRE_EN
   localparam logic EXP_PEND_AFTER_2 = 1'b0;
`else
   localparam logic EXP_PEND_AFTER_2 = 1'b1;
`endif

   pacman_input_sequencer #(
      .BUF_TICKS (2),
      .INIT_DIR  (2'd1)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_move_up     (move_up),
      .i_move_down   (move_down),
      .i_move_left   (move_left),
      .i_move_right  (move_right),
      .i_start_game  (start_game),
      .i_tile_step   (tile_step),
      .i_wall_mask   (wall_mask),
      .i_game_over   (game_over),
      .o_cur_dir     (cur_dir),
      .o_moving      (moving),
      .o_req_pending (req_pending),
      .o_req_dir     (req_dir),
      .o_game_state  (game_state),
      .o_game_active (game_active)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drive one cycle of inputs, then release them 1 time unit after the edge.
   task automatic step(input logic [3:0] keys, input logic st, input logic ts,
                       input logic [3:0] wm, input logic go);
      move_up    = keys[0];
      move_left  = keys[1];
      move_down  = keys[2];
      move_right = keys[3];
      start_game = st;
      tile_step  = ts;
      wall_mask  = wm;
      game_over  = go;
      @(posedge clk);
      #1;
      move_up = 0; move_left = 0; move_down = 0; move_right = 0;
      start_game = 0; tile_step = 0; wall_mask = 4'b0000; game_over = 0;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_state"},   {2'b00, game_state}, 4'd0);
      chk({tag, "_cur"},     {2'b00, cur_dir},    4'd1);
      chk({tag, "_moving"},  {3'b000, moving},    4'd0);
      chk({tag, "_pend"},    {3'b000, req_pending}, 4'd0);
      chk({tag, "_reqdir"},  {2'b00, req_dir},    4'd0);
      chk({tag, "_active"},  {3'b000, game_active}, 4'd0);
   endtask

   initial begin
      rst_n = 0;
      move_up = 0; move_left = 0; move_down = 0; move_right = 0;
      start_game = 0; tile_step = 0; wall_mask = 4'b0000; game_over = 0;
      #22;
      chk_reset("rst");
      @(negedge clk);
      rst_n = 1;

      step(K_UP, 0, 0, 4'b0000, 0);
      chk("idle_key_ignored", {3'b000, req_pending}, 4'd0);

      step(K_NONE, 1, 0, 4'b0000, 0);
      chk("start_state", {2'b00, game_state}, 4'd1);
      chk("start_moving", {3'b000, moving}, 4'd1);
      chk("start_cur", {2'b00, cur_dir}, 4'd1);
      chk("start_active", {3'b000, game_active}, 4'd1);

      step(K_UP, 0, 0, 4'b0000, 0);
      chk("up_pend", {3'b000, req_pending}, 4'd1);
      chk("up_reqdir", {2'b00, req_dir}, 4'd0);
      step(K_NONE, 0, 1, 4'b0001, 0);
      chk("blocked_pend", {3'b000, req_pending}, 4'd1);
      chk("blocked_moving", {3'b000, moving}, 4'd1);
      chk("blocked_cur", {2'b00, cur_dir}, 4'd1);
      step(K_NONE, 0, 1, 4'b0000, 0);
      chk("commit_cur", {2'b00, cur_dir}, 4'd0);
      chk("commit_pend", {3'b000, req_pending}, 4'd0);

      step(K_LEFT, 0, 0, 4'b0000, 0);
      step(K_NONE, 0, 1, 4'b0000, 0);
      chk("back_left", {2'b00, cur_dir}, 4'd1);
      step(K_RIGHT, 0, 0, 4'b0000, 0);
      chk("rev_cur", {2'b00, cur_dir}, 4'd3);
      chk("rev_moving", {3'b000, moving}, 4'd1);
      step(K_UP | K_RIGHT, 0, 0, 4'b0000, 0);
      chk("prio_reqdir", {2'b00, req_dir}, 4'd0);
      chk("prio_pend", {3'b000, req_pending}, 4'd1);

      step(K_DOWN, 0, 0, 4'b0000, 0);
      chk("overwrite_reqdir", {2'b00, req_dir}, 4'd2);
      step(K_NONE, 0, 1, 4'b0100, 0);
      chk("exp1_pend", {3'b000, req_pending}, 4'd1);
      chk("exp1_moving", {3'b000, moving}, 4'd1);
      step(K_NONE, 0, 1, 4'b0100, 0);
      chk("exp2_pend", {3'b000, req_pending}, {3'b000, EXP_PEND_AFTER_2});
      step(K_RIGHT, 0, 0, 4'b0000, 0);
      chk("same_dir_clear", {3'b000, req_pending}, 4'd0);
      chk("same_dir_cur", {2'b00, cur_dir}, 4'd3);

      step(K_LEFT, 0, 0, 4'b0000, 0);
      chk("rev_left", {2'b00, cur_dir}, 4'd1);
      step(K_NONE, 0, 1, 4'b0010, 0);
      chk("wall_stop", {3'b000, moving}, 4'd0);
      step(K_RIGHT, 0, 0, 4'b0000, 0);
      chk("restart_moving", {3'b000, moving}, 4'd1);
      chk("restart_cur", {2'b00, cur_dir}, 4'd3);

      step(K_UP, 0, 1, 4'b0000, 0);
      chk("samecyc_cur", {2'b00, cur_dir}, 4'd0);
      chk("samecyc_pend", {3'b000, req_pending}, 4'd0);

      step(K_LEFT, 0, 0, 4'b0000, 0);
      step(K_NONE, 1, 0, 4'b0000, 0);
      chk("pause_state", {2'b00, game_state}, 4'd2);
      chk("pause_moving", {3'b000, moving}, 4'd0);
      chk("pause_active", {3'b000, game_active}, 4'd0);
      chk("pause_pend", {3'b000, req_pending}, 4'd1);
      step(K_DOWN, 0, 0, 4'b0000, 0);
      step(K_NONE, 0, 1, 4'b0000, 0);
      step(K_NONE, 0, 0, 4'b0000, 1);
      chk("pause_frozen_cur", {2'b00, cur_dir}, 4'd0);
      chk("pause_frozen_req", {2'b00, req_dir}, 4'd1);
      chk("pause_go_ignored", {2'b00, game_state}, 4'd2);
      step(K_NONE, 1, 0, 4'b0000, 0);
      chk("resume_state", {2'b00, game_state}, 4'd1);
      chk("resume_moving", {3'b000, moving}, 4'd1);
      step(K_NONE, 0, 1, 4'b0000, 0);
      chk("resume_commit", {2'b00, cur_dir}, 4'd1);

      step(K_RIGHT, 0, 0, 4'b0000, 0);
      step(K_UP, 0, 0, 4'b0000, 0);
      step(K_NONE, 1, 0, 4'b0000, 1);
      chk("over_state", {2'b00, game_state}, 4'd3);
      chk("over_pend", {3'b000, req_pending}, 4'd0);
      chk("over_moving", {3'b000, moving}, 4'd0);
      step(K_NONE, 1, 0, 4'b0000, 0);
      chk("idle_state", {2'b00, game_state}, 4'd0);
      chk("idle_cur", {2'b00, cur_dir}, 4'd1);

      step(K_NONE, 1, 0, 4'b0000, 0);
      step(K_UP, 0, 0, 4'b0000, 0);
      chk("pre_rst_pend", {3'b000, req_pending}, 4'd1);
      rst_n = 0;
      #1;
      chk_reset("midrst");
      #20;
      rst_n = 1;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pacman_input_sequencer.md
Name: pacman_input_sequencer

Overview:
Sits between the UART keyboard decoder and the Pac-Man movement/game logic.
- Runs the top-level game state machine (idle/play/pause/over) from start pulses.
- Buffers the most recent direction keypress and commits it at tile boundaries only when the target direction is not walled.
- Applies reversals immediately, so single-cycle key pulses become a stable current direction for the sprite engine.

Parameters:
BUF_TICKS, 4, number of tile_step strobes a buffered turn request survives before expiring (1..15).
INIT_DIR, 2'd1, direction loaded into cur_dir at reset and on return to IDLE (LEFT).

Ports:
clk  in  1  system clock.
rst_n  in  1  reset; asynchronous, active-low.
move_up  in  1  one-cycle pulse, W key.
move_down  in  1  one-cycle pulse, S key.
move_left  in  1  one-cycle pulse, A key.
move_right  in  1  one-cycle pulse, D key.
start_game  in  1  one-cycle pulse, Enter key.
tile_step  in  1  one-cycle strobe; sprite is centred on a tile.
wall_mask  in  4  walls at current tile; bit index = direction code; 1 = blocked; sampled only on tile_step.
game_over  in  1  level, asserted by game logic when lives are exhausted.
cur_dir  out  2  committed direction code.
moving  out  1  sprite advances along cur_dir.
req_pending  out  1  a buffered turn request is held.
req_dir  out  2  buffered request direction (valid when req_pending).
game_state  out  2  0 IDLE, 1 PLAY, 2 PAUSE, 3 OVER.
game_active  out  1  high only in PLAY.

Behaviour:
- Reset values: game_state=IDLE, cur_dir=INIT_DIR, moving=0, req_pending=0, req_dir=0, game_active=0, expiry counter=0. All outputs are registered.
- Direction codes: UP=0, LEFT=1, DOWN=2, RIGHT=3. The reverse of d is d XOR 2.
- Key merge: if several move pulses arrive in one cycle, priority is UP > LEFT > DOWN > RIGHT. Exactly one candidate is produced per cycle.
- FSM transitions, one per cycle, on start_game unless noted:
  - IDLE --start--> PLAY; moving=1 on entry.
  - PLAY --start--> PAUSE.
  - PLAY --game_over--> OVER; game_over wins over start in the same cycle.
  - PAUSE --start--> PLAY.
  - OVER --start--> IDLE; cur_dir=INIT_DIR, request cleared, moving=0.
  - game_over is ignored outside PLAY.
- Outside PLAY:
  - Move pulses are ignored.
  - tile_step is ignored.
  - moving=0.
  - The request buffer is frozen in PAUSE and cleared in IDLE/OVER.
  - On PAUSE->PLAY, moving is restored to its value before the pause.
- In PLAY, candidate handling (takes effect the cycle after the pulse):
  - candidate == reverse(cur_dir): cur_dir<=candidate, moving<=1, request cleared. No wall check.
  - candidate == cur_dir: request cleared, no other change.
  - Otherwise: req_dir<=candidate, req_pending<=1, counter<=BUF_TICKS. A newer key overwrites an older request.
- In PLAY, on tile_step, evaluated against wall_mask:
  - If req_pending and wall_mask[req_dir]==0: cur_dir<=req_dir, moving<=1, request cleared.
  - Else if wall_mask[cur_dir]==1: moving<=0; request kept.
  - Else: moving<=1.
  - If a request remains pending after this evaluation, counter decrements. When it reaches 0, req_pending<=0.
- Same-cycle candidate and tile_step: the candidate is processed first, so the tile_step evaluation uses the new request/cur_dir.
- The counter is 4 bits and saturates at 0; no wrap.
- Stopped at a wall (moving=0): a later legal request commits on the next tile_step. A reversal restarts movement immediately.

Optional Feature:
TURN_EXPIRE_EN:
- Defined: the BUF_TICKS expiry counter is implemented as described.
- Undefined: the counter is removed. A request persists until committed, overwritten, cancelled by reversal/same-direction key, or cleared by IDLE/OVER. BUF_TICKS is unused.

Decomposition:
- Package pacman_pkg holds:
  - direction codes DIR_UP/LEFT/DOWN/RIGHT and a dir_t 2-bit typedef;
  - game_state_t with codes GS_IDLE/PLAY/PAUSE/OVER;
  - a reverse_dir function.
- One sub-module, pacman_turn_buffer, holds req_dir, req_pending and the expiry counter. Ports: load, clear, tick, commit.
- The FSM and wall evaluation stay in the top.

Test Plan:
- Reset, start pulse -> game_state 0->1 next cycle, moving=1, cur_dir=1.
- PLAY, cur_dir=LEFT, move_up pulse, then tile_step with wall_mask=4'b0001 -> turn rejected, req_pending stays 1, moving=1. Next tile_step with wall_mask=4'b0000 -> cur_dir=0, req_pending=0.
- cur_dir=LEFT, move_right pulse -> cur_dir=3 one cycle later with no tile_step. Same cycle move_up+move_right -> up wins, req_dir=0.
- BUF_TICKS=2, request DOWN, two tile_steps with wall_mask[2]=1 -> req_pending=0 after second step. Without TURN_EXPIRE_EN -> still 1.
- cur_dir=LEFT, tile_step with wall_mask=4'b0010, no request -> moving=0. Then move_right -> moving=1, cur_dir=3.
- PLAY with game_over and start in same cycle -> state 3. Start -> state 0, cur_dir=1. rst_n low mid-PLAY with request pending -> all outputs at reset values immediately.
